// File: rtl/cache_flush_ctrl_pkg.sv
// Shared constants for the cache flush controller:
// FSM state encoding and cacheable-region address decode bounds.
package cache_flush_ctrl_pkg;

    localparam logic [1:0] INIT_SWEEP = 2'd0;
    localparam logic [1:0] IDLE       = 2'd1;
    localparam logic [1:0] SWEEP      = 2'd2;

    // Each cacheable-area bit covers one 2 MB region
    localparam int REGION_SHIFT = 21;
    localparam int REGION_LO    = REGION_SHIFT;
    localparam int REGION_HI    = 25;

endpackage

// File: rtl/cache_flush_ctrl.sv
// Tag RAM invalidate sequencer with core stall, plus the
// per-access cacheable decode from the coprocessor area mask.
module cache_flush_ctrl
    import cache_flush_ctrl_pkg::*;
#(
    parameter  int LINES     = 256,
    parameter  int WAYS      = 4,
    parameter  int TAG_WIDTH = 21,
    localparam int LW        = $clog2(LINES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cache_enable,
    input  logic                 i_cache_flush,
    input  logic [31:0]          i_cacheable_area,
    input  logic [31:0]          i_address,
    output logic                 o_cacheable,
    output logic                 o_stall,
    output logic [WAYS-1:0]      o_tag_wenable,
    output logic [LW-1:0]        o_tag_waddr,
    output logic [TAG_WIDTH-1:0] o_tag_wdata,
    output logic                 o_flush_done
);

    logic [1:0]    state;
    logic [LW-1:0] count;
    logic          pending;
    logic          done;
    logic          sweeping;
    logic          last;
    logic [4:0]    region;
    logic          unused_addr;

    assign sweeping = (state != IDLE);
    assign last     = sweeping && (count == LW'(LINES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= INIT_SWEEP;
            count   <= '0;
            pending <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= last;
            case (state)
                IDLE: begin
                    if (i_cache_flush)
                        state <= SWEEP;
                end
                default: begin
                    count <= count + LW'(1);
                    if (last) begin
                        // A queued flush chains straight into a new sweep
                        state   <= (pending || i_cache_flush) ? SWEEP : IDLE;
                        pending <= 1'b0;
                    end else begin
                        pending <= pending | i_cache_flush;
                    end
                end
            endcase
        end
    end

    assign o_tag_wenable = {WAYS{sweeping & ~i_rst}};
    assign o_tag_waddr   = count;
    assign o_tag_wdata   = '0;
    assign o_flush_done  = done;
    assign o_stall       = i_rst | i_cache_flush | sweeping | pending;

    assign region      = i_address[REGION_HI:REGION_LO];
    assign o_cacheable = i_cache_enable
                       && (i_address[31:REGION_HI+1] == '0)
                       && i_cacheable_area[region]
                       && !sweeping;

    assign unused_addr = ^i_address[REGION_LO-1:0];

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Self-checking bench for cache_flush_ctrl: scoreboarded sweep
// sequences plus a table of cacheable-decode vectors.
module tb_cache_flush_ctrl;

    localparam int LINES = 256;
    localparam int WAYS  = 4;
    localparam int TW    = 21;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic [31:0] area;
    logic [31:0] addr;
    logic        cach;
    logic        stall;
    logic [3:0]  wen;
    logic [7:0]  waddr;
    logic [TW-1:0] wdata;
    logic        done;

    cache_flush_ctrl #(.LINES(LINES), .WAYS(WAYS), .TAG_WIDTH(TW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_cache_enable  (en),
        .i_cache_flush   (flush),
        .i_cacheable_area(area),
        .i_address       (addr),
        .o_cacheable     (cach),
        .o_stall         (stall),
        .o_tag_wenable   (wen),
        .o_tag_waddr     (waddr),
        .o_tag_wdata     (wdata),
        .o_flush_done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] wen;
        logic [7:0] addr;
        logic       done;
        logic       stall;
        logic       cach;
        bit         chk_c;
    } exp_t;

    typedef struct {
        logic        en;
        logic [31:0] area;
        logic [31:0] addr;
        logic        exp;
    } cvec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(logic [3:0] w, logic [7:0] a,
                                logic d, logic s);
        exp_t e;
        e.wen   = w;
        e.addr  = a;
        e.done  = d;
        e.stall = s;
        e.cach  = 1'b0;
        e.chk_c = 1'b0;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic sample(exp_t e);
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        check("wenable", 32'(wen), 32'(x.wen));
        check("waddr", 32'(waddr), 32'(x.addr));
        check("done", 32'(done), 32'(x.done));
        check("stall", 32'(stall), 32'(x.stall));
        check("wdata", 32'(wdata), 32'd0);
        if (x.chk_c)
            check("cacheable", 32'(cach), 32'(x.cach));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(exp_t e);
        sample(e);
        adv();
    endtask

    task automatic full_sweep();
        for (int i = 0; i < LINES; i++)
            cyc(mk(4'hF, 8'(i), 1'b0, 1'b1));
        cyc(mk(4'h0, 8'h00, 1'b1, 1'b0));
    endtask

    task automatic strobe_idle();
        flush = 1'b1;
        cyc(mk(4'h0, 8'h00, 1'b0, 1'b1));
        flush = 1'b0;
    endtask

    cvec_t cv[10];
    exp_t  ec;

    initial begin
        cv[0] = '{1'b1, 32'h0000_0003, 32'h0030_0000, 1'b1};
        cv[1] = '{1'b1, 32'h0000_0003, 32'h0040_0000, 1'b0};
        cv[2] = '{1'b1, 32'h0000_0003, 32'h0400_0000, 1'b0};
        cv[3] = '{1'b0, 32'h0000_0003, 32'h0000_1000, 1'b0};
        cv[4] = '{1'b1, 32'h0000_0003, 32'h0000_1000, 1'b1};
        cv[5] = '{1'b1, 32'h8000_0000, 32'h03E0_0000, 1'b1};
        cv[6] = '{1'b1, 32'h0000_0003, 32'h03FF_FFFF, 1'b0};
        cv[7] = '{1'b1, 32'h0000_0002, 32'h0020_0000, 1'b1};
        cv[8] = '{1'b1, 32'hFFFF_FFFF, 32'hFC20_0000, 1'b0};
        cv[9] = '{1'b1, 32'hFFFF_FFFE, 32'h001F_FFFF, 1'b0};

        rst = 1'b1; en = 1'b0; flush = 1'b0;
        area = 32'h0; addr = 32'h0;
        adv();
        cyc(mk(4'h0, 8'h00, 1'b0, 1'b1));
        cyc(mk(4'h0, 8'h00, 1'b0, 1'b1));

        // Init sweep right out of reset
        rst = 1'b0;
        full_sweep();
        cyc(mk(4'h0, 8'h00, 1'b0, 1'b0));

        // Flush from IDLE
        strobe_idle();
        full_sweep();
        cyc(mk(4'h0, 8'h00, 1'b0, 1'b0));

        // Two strobes mid-sweep collapse into one rerun
        strobe_idle();
        for (int i = 0; i < LINES; i++) begin
            flush = (i == 100 || i == 150);
            cyc(mk(4'hF, 8'(i), 1'b0, 1'b1));
        end
        flush = 1'b0;
        cyc(mk(4'hF, 8'h00, 1'b1, 1'b1));
        for (int i = 1; i < LINES; i++)
            cyc(mk(4'hF, 8'(i), 1'b0, 1'b1));
        cyc(mk(4'h0, 8'h00, 1'b1, 1'b0));
        cyc(mk(4'h0, 8'h00, 1'b0, 1'b0));

        // Cacheable decode vectors in IDLE
        for (int i = 0; i < 10; i++) begin
            en   = cv[i].en;
            area = cv[i].area;
            addr = cv[i].addr;
            ec = mk(4'h0, 8'h00, 1'b0, 1'b0);
            ec.chk_c = 1'b1;
            ec.cach  = cv[i].exp;
            cyc(ec);
        end

        // Async reset mid-sweep at line 77
        strobe_idle();
        for (int i = 0; i < 77; i++)
            cyc(mk(4'hF, 8'(i), 1'b0, 1'b1));
        sample(mk(4'hF, 8'd77, 1'b0, 1'b1));
        #2 rst = 1'b1;
        #1;
        check("rst_wen_drop", 32'(wen), 32'h0);
        check("rst_stall", 32'(stall), 32'h1);
        check("rst_waddr", 32'(waddr), 32'h0);
        adv();
        cyc(mk(4'h0, 8'h00, 1'b0, 1'b1));
        rst = 1'b0;
        full_sweep();
        cyc(mk(4'h0, 8'h00, 1'b0, 1'b0));

        // Enable drop mid-sweep: sweep completes, cacheable held low
        en = 1'b1; area = 32'hFFFF_FFFF; addr = 32'h0000_1000;
        ec = mk(4'h0, 8'h00, 1'b0, 1'b0);
        ec.chk_c = 1'b1; ec.cach = 1'b1;
        cyc(ec);
        flush = 1'b1;
        ec = mk(4'h0, 8'h00, 1'b0, 1'b1);
        ec.chk_c = 1'b1; ec.cach = 1'b1;
        cyc(ec);
        flush = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            if (i == 50)
                en = 1'b0;
            ec = mk(4'hF, 8'(i), 1'b0, 1'b1);
            ec.chk_c = 1'b1; ec.cach = 1'b0;
            cyc(ec);
        end
        ec = mk(4'h0, 8'h00, 1'b1, 1'b0);
        ec.chk_c = 1'b1; ec.cach = 1'b0;
        cyc(ec);
        en = 1'b1;
        ec = mk(4'h0, 8'h00, 1'b0, 1'b0);
        ec.chk_c = 1'b1; ec.cach = 1'b1;
        cyc(ec);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
